// File: rtl/lead_one_norm_pipe.sv
// Leading/trailing one detector with normaliser, elastic valid/ready pipeline.
// Trailing-one searches bit-reverse the operand on entry, so every stage runs
// the same leading-zero binary search. The final reverse on the output
// restores the LSB-aligned result. Each tree level tests whether the top
// 2^b bits of the working window are clear. If they are, it sets count bit b
// and shifts the window left by 2^b. The shift is therefore complete once
// the last level has run.
module lead_one_norm_pipe #(
    parameter int WIDTH     = 32,
    parameter int BIT_WIDTH = $clog2(WIDTH),
    parameter int STAGES    = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_mode,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [BIT_WIDTH-1:0] o_count,
    output logic                 o_zero,
    output logic [WIDTH-1:0]     o_norm,
    output logic [TAG_WIDTH-1:0] o_tag
);

    localparam logic [WIDTH-1:0] ONES = '1;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // Per-stage registers. The window is held in the search (possibly reversed) domain.
    logic [STAGES-1:0]    r_valid;
    logic [WIDTH-1:0]     r_win  [STAGES];
    logic [BIT_WIDTH-1:0] r_cnt  [STAGES];
    logic                 r_mode [STAGES];
    logic                 r_zero [STAGES];
    logic [TAG_WIDTH-1:0] r_tag  [STAGES];

    // Next-stage values after this stage's share of the tree levels.
    logic [STAGES-1:0]    w_in_valid;
    logic [WIDTH-1:0]     w_win  [STAGES];
    logic [BIT_WIDTH-1:0] w_cnt  [STAGES];
    logic                 w_mode [STAGES];
    logic                 w_zero [STAGES];
    logic [TAG_WIDTH-1:0] w_tag  [STAGES];

    // w_go: stage hands its contents on this cycle; w_load: stage may capture.
    logic [STAGES-1:0]    w_go;
    logic [STAGES-1:0]    w_load;

    // Backpressure chain, resolved from the output end toward the input.
    always_comb begin
        w_go = '0;
        w_go[STAGES-1] = r_valid[STAGES-1] & i_ready;
        for (int s = STAGES - 2; s >= 0; s--) begin
            w_go[s] = r_valid[s] & (~r_valid[s+1] | w_go[s+1]);
        end
        w_load = ~r_valid | w_go;
    end

    // Stage inputs and the tree levels owned by each stage, split evenly.
    always_comb begin
        int p;
        int lo;
        int hi;
        int sh;
        for (int s = 0; s < STAGES; s++) begin
            p  = (s == 0) ? 0 : s - 1;
            lo = (s * BIT_WIDTH) / STAGES;
            hi = ((s + 1) * BIT_WIDTH) / STAGES;
            if (s == 0) begin
                w_in_valid[s] = i_valid;
                w_win[s]      = i_mode ? bit_rev(i_data) : i_data;
                w_cnt[s]      = '0;
                w_mode[s]     = i_mode;
                w_zero[s]     = (i_data == '0);
                w_tag[s]      = i_tag;
            end else begin
                w_in_valid[s] = r_valid[p];
                w_win[s]      = r_win[p];
                w_cnt[s]      = r_cnt[p];
                w_mode[s]     = r_mode[p];
                w_zero[s]     = r_zero[p];
                w_tag[s]      = r_tag[p];
            end
            for (int k = 0; k < BIT_WIDTH; k++) begin
                sh = 1 << (BIT_WIDTH - 1 - k);
                if (k >= lo && k < hi && (w_win[s] & ~(ONES >> sh)) == '0) begin
                    w_win[s] = w_win[s] << sh;
                    w_cnt[s][BIT_WIDTH-1-k] = 1'b1;
                end
            end
        end
    end

    // Pipeline registers. Payload is captured only with a valid transaction,
    // so an emptied last stage keeps showing the last delivered result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_win[s]  <= '0;
                r_cnt[s]  <= '0;
                r_mode[s] <= 1'b0;
                r_zero[s] <= 1'b0;
                r_tag[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_load[s]) begin
                    r_valid[s] <= w_in_valid[s];
                    if (w_in_valid[s]) begin
                        r_win[s]  <= w_win[s];
                        r_cnt[s]  <= w_cnt[s];
                        r_mode[s] <= w_mode[s];
                        r_zero[s] <= w_zero[s];
                        r_tag[s]  <= w_tag[s];
                    end
                end
            end
        end
    end

    assign o_ready = w_load[0];
    assign o_valid = r_valid[STAGES-1];
    assign o_count = r_cnt[STAGES-1];
    assign o_zero  = r_zero[STAGES-1];
    assign o_tag   = r_tag[STAGES-1];
    assign o_norm  = r_mode[STAGES-1] ? bit_rev(r_win[STAGES-1]) : r_win[STAGES-1];

endmodule

// File: tb/tb_lead_one_norm_pipe.sv
// Bench for lead_one_norm_pipe. A 32-bit, 2-stage instance gets directed
// vectors, a backpressure sequence and a reset-with-traffic scenario. A set of
// other WIDTH/STAGES instances get random traffic scored against a reference model.
`timescale 1ns/1ps
module tb_lead_one_norm_pipe;

    localparam int NCFG = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_sw_n;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [NCFG-1:0] sw_done;

    function automatic int cfg_w(input int i);
        case (i)
            0: return 4;
            1: return 4;
            2: return 8;
            3: return 64;
            4: return 64;
            5: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            4: return 5;
            5: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: locate the extreme set bit by plain scanning, then shift.
    task automatic ref_model(input logic [63:0] d_in, input logic mode, input int w,
                             output logic [63:0] cnt, output logic zero, output logic [63:0] norm);
        logic [63:0] mask;
        logic [63:0] d;
        int idx;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        d    = d_in & mask;
        zero = (d == 64'd0);
        cnt  = 64'(w - 1);
        norm = 64'd0;
        idx  = 0;
        if (!zero) begin
            if (!mode) begin
                for (int i = 0; i < w; i++) if (d[i]) idx = i;
                cnt  = 64'(w - 1 - idx);
                norm = (d << cnt) & mask;
            end else begin
                for (int i = w - 1; i >= 0; i--) if (d[i]) idx = i;
                cnt  = 64'(idx);
                norm = d >> cnt;
            end
        end
    endtask

    // ---------------- main 32-bit, 2-stage instance ----------------
    logic        m_valid, m_ready, m_mode, m_ovalid, m_iready, m_zero;
    logic [31:0] m_data, m_norm;
    logic [4:0]  m_count;
    logic [3:0]  m_tag, m_otag;

    lead_one_norm_pipe #(.WIDTH(32), .STAGES(2), .TAG_WIDTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (m_valid),
        .o_ready (m_ready),
        .i_data  (m_data),
        .i_mode  (m_mode),
        .i_tag   (m_tag),
        .o_valid (m_ovalid),
        .i_ready (m_iready),
        .o_count (m_count),
        .o_zero  (m_zero),
        .o_norm  (m_norm),
        .o_tag   (m_otag)
    );

    task automatic single_txn(input string nm, input logic [31:0] d, input logic m, input logic [3:0] t,
                              input logic [63:0] ec, input logic ez, input logic [63:0] en);
        int lat;
        @(posedge clk); #1;
        m_valid = 1'b1; m_data = d; m_mode = m; m_tag = t; m_iready = 1'b1;
        @(negedge clk);
        check_val({nm, "_ready"}, 64'(m_ready), 64'd1);
        @(posedge clk); #1;
        m_valid = 1'b0;
        lat = 1;
        while (!m_ovalid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({nm, "_latency"}, 64'(lat), 64'd2);
        check_val({nm, "_count"}, 64'(m_count), ec);
        check_val({nm, "_zero"}, 64'(m_zero), 64'(ez));
        check_val({nm, "_norm"}, 64'(m_norm), en);
        check_val({nm, "_tag"}, 64'(m_otag), 64'(t));
        @(posedge clk); #1;
        check_val({nm, "_drained"}, 64'(m_ovalid), 64'd0);
        check_val({nm, "_kept"}, 64'(m_count), ec);
    endtask

    initial begin
        logic [31:0] bpd [8];
        logic        bpm [8];
        logic [63:0] ec, en;
        logic        ez, hold_pend, stale;
        logic [4:0]  h_cnt;
        logic [31:0] h_norm;
        logic        h_zero;
        logic [3:0]  h_tag;
        int sent, got, inflight, t;

        m_valid = 1'b0; m_data = '0; m_mode = 1'b0; m_tag = '0; m_iready = 1'b1;
        rst_n = 1'b0;
        #2;
        check_val("rst_valid", 64'(m_ovalid), 64'd0);
        check_val("rst_count", 64'(m_count), 64'd0);
        check_val("rst_zero", 64'(m_zero), 64'd0);
        check_val("rst_norm", 64'(m_norm), 64'd0);
        check_val("rst_tag", 64'(m_otag), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", 64'(m_ready), 64'd1);

        single_txn("lead_8000", 32'h0000_8000, 1'b0, 4'h1, 64'd16, 1'b0, 64'h8000_0000);
        single_txn("trail_8000", 32'h0000_8000, 1'b1, 4'h2, 64'd15, 1'b0, 64'h0000_0001);
        single_txn("lead_zero", 32'h0, 1'b0, 4'h3, 64'd31, 1'b1, 64'h0);
        single_txn("trail_zero", 32'h0, 1'b1, 4'h4, 64'd31, 1'b1, 64'h0);
        single_txn("lead_ends", 32'h8000_0001, 1'b0, 4'h5, 64'd0, 1'b0, 64'h8000_0001);
        single_txn("trail_ends", 32'h8000_0001, 1'b1, 4'h6, 64'd0, 1'b0, 64'h8000_0001);

        // 8 back-to-back operands with i_ready toggling every cycle.
        for (int i = 0; i < 8; i++) begin
            bpd[i] = $urandom >> $urandom_range(0, 31);
            bpm[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; hold_pend = 1'b0;
        h_cnt = '0; h_norm = '0; h_zero = 1'b0; h_tag = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(posedge clk); #1;
            m_valid = (sent < 8);
            m_data  = bpd[(sent < 8) ? sent : 7];
            m_mode  = bpm[(sent < 8) ? sent : 7];
            m_tag   = 4'(sent);
            m_iready = (cyc % 2 == 0);
            @(negedge clk);
            if (hold_pend) begin
                check_val("bp_hold_valid", 64'(m_ovalid), 64'd1);
                check_val("bp_hold_count", 64'(m_count), 64'(h_cnt));
                check_val("bp_hold_norm", 64'(m_norm), 64'(h_norm));
                check_val("bp_hold_zero", 64'(m_zero), 64'(h_zero));
                check_val("bp_hold_tag", 64'(m_otag), 64'(h_tag));
            end
            inflight = sent - got;
            check_val("bp_ready", 64'(m_ready), 64'(!(inflight == 2 && !m_iready)));
            if (m_ovalid && m_iready) begin
                check_val("bp_in_range", 64'(got < 8), 64'd1);
                if (got < 8) begin
                    ref_model(64'(bpd[got]), bpm[got], 32, ec, ez, en);
                    check_val("bp_tag_order", 64'(m_otag), 64'(got));
                    check_val("bp_count", 64'(m_count), ec);
                    check_val("bp_zero", 64'(m_zero), 64'(ez));
                    check_val("bp_norm", 64'(m_norm), en);
                end
                got++;
            end
            hold_pend = m_ovalid && !m_iready;
            h_cnt = m_count; h_norm = m_norm; h_zero = m_zero; h_tag = m_otag;
            if (m_valid && m_ready) sent++;
        end
        check_val("bp_all_out", 64'(got), 64'd8);

        // Reset with two transactions in flight.
        @(posedge clk); #1;
        m_iready = 1'b1; m_valid = 1'b1; m_data = 32'h00F0_0000; m_mode = 1'b0; m_tag = 4'hA;
        @(posedge clk); #1;
        m_data = 32'h0000_0003; m_tag = 4'hB;
        @(posedge clk); #1;
        m_valid = 1'b0;
        check_val("inflight_valid", 64'(m_ovalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 64'(m_ovalid), 64'd0);
        check_val("async_rst_count", 64'(m_count), 64'd0);
        check_val("async_rst_norm", 64'(m_norm), 64'd0);
        check_val("async_rst_tag", 64'(m_otag), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst2", 64'(m_ready), 64'd1);
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_ovalid) stale = 1'b1;
        end
        check_val("no_stale_result", 64'(stale), 64'd0);

        t = 0;
        while (sw_done != {NCFG{1'b1}} && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check_val("sweep_done", 64'(sw_done), 64'({NCFG{1'b1}}));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        rst_sw_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_sw_n = 1'b1;
    end

    // ---------------- parameter sweep with random traffic ----------------
    for (genvar c = 0; c < NCFG; c++) begin : g_sw
        localparam int CW = cfg_w(c);
        localparam int CS = cfg_s(c);
        localparam int CB = $clog2(CW);

        logic          s_valid, s_ready, s_mode, s_ovalid, s_iready, s_zero, done;
        logic [CW-1:0] s_data, s_norm;
        logic [CB-1:0] s_count;
        logic [3:0]    s_tag, s_otag;

        lead_one_norm_pipe #(.WIDTH(CW), .STAGES(CS), .TAG_WIDTH(4)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_sw_n),
            .i_valid (s_valid),
            .o_ready (s_ready),
            .i_data  (s_data),
            .i_mode  (s_mode),
            .i_tag   (s_tag),
            .o_valid (s_ovalid),
            .i_ready (s_iready),
            .o_count (s_count),
            .o_zero  (s_zero),
            .o_norm  (s_norm),
            .o_tag   (s_otag)
        );

        assign sw_done[c] = done;

        initial begin : run
            logic [63:0]   qd [$];
            logic          qm [$];
            logic [3:0]    qt [$];
            int            qc [$];
            logic [63:0]   d64, ec, en;
            logic          ez, acc, hold_pend;
            logic [CW-1:0] h_norm;
            logic [CB-1:0] h_cnt;
            logic          h_zero;
            logic [3:0]    h_tag;

            done = 1'b0;
            s_valid = 1'b0; s_data = '0; s_mode = 1'b0; s_tag = '0; s_iready = 1'b1;
            acc = 1'b0; hold_pend = 1'b0;
            h_norm = '0; h_cnt = '0; h_zero = 1'b0; h_tag = '0;
            repeat (5) @(posedge clk);
            for (int cyc = 0; cyc < 900; cyc++) begin
                @(posedge clk); #1;
                if (!s_valid || acc) begin
                    if (cyc < 860 && $urandom_range(0, 3) != 0) begin
                        d64 = {$urandom, $urandom};
                        case ($urandom_range(0, 5))
                            0: d64 = 64'd0;
                            1: d64 = 64'd1 << $urandom_range(0, CW - 1);
                            2: d64 = d64 >> $urandom_range(0, 63);
                            3: d64 = d64 << $urandom_range(0, CW - 1);
                            default: ;
                        endcase
                        s_valid = 1'b1;
                        s_data  = d64[CW-1:0];
                        s_mode  = 1'($urandom_range(0, 1));
                        s_tag   = 4'($urandom);
                    end else begin
                        s_valid = 1'b0;
                    end
                end
                s_iready = (cyc < 300 || cyc >= 860) ? 1'b1 : ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (hold_pend) begin
                    check_val($sformatf("c%0d_hold_valid", c), 64'(s_ovalid), 64'd1);
                    check_val($sformatf("c%0d_hold_count", c), 64'(s_count), 64'(h_cnt));
                    check_val($sformatf("c%0d_hold_norm", c), 64'(s_norm), 64'(h_norm));
                    check_val($sformatf("c%0d_hold_zero", c), 64'(s_zero), 64'(h_zero));
                    check_val($sformatf("c%0d_hold_tag", c), 64'(s_otag), 64'(h_tag));
                end
                check_val($sformatf("c%0d_ready", c), 64'(s_ready),
                          64'(!(qd.size() == CS && !s_iready)));
                if (s_ovalid && s_iready) begin
                    check_val($sformatf("c%0d_expected_out", c), 64'(qd.size() != 0), 64'd1);
                    if (qd.size() != 0) begin
                        ref_model(qd[0], qm[0], CW, ec, ez, en);
                        check_val($sformatf("c%0d_count", c), 64'(s_count), ec);
                        check_val($sformatf("c%0d_zero", c), 64'(s_zero), 64'(ez));
                        check_val($sformatf("c%0d_norm", c), 64'(s_norm), en);
                        check_val($sformatf("c%0d_tag", c), 64'(s_otag), 64'(qt[0]));
                        if (qc[0] + CS < 300)
                            check_val($sformatf("c%0d_latency", c), 64'(cyc - qc[0]), 64'(CS));
                        void'(qd.pop_front());
                        void'(qm.pop_front());
                        void'(qt.pop_front());
                        void'(qc.pop_front());
                    end
                end
                hold_pend = s_ovalid && !s_iready;
                h_norm = s_norm; h_cnt = s_count; h_zero = s_zero; h_tag = s_otag;
                acc = s_valid && s_ready;
                if (acc) begin
                    qd.push_back(64'(s_data));
                    qm.push_back(s_mode);
                    qt.push_back(s_tag);
                    qc.push_back(cyc);
                end
            end
            check_val($sformatf("c%0d_drained", c), 64'(qd.size()), 64'd0);
            done = 1'b1;
        end
    end

endmodule
